// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand select, valE, CC register, branch/cmov condition,
// and the E/M pipeline register with stall/bubble control.
module execute_stage #(
  parameter int unsigned W     = 64,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e_valid,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] e_valA,
  input  logic [W-1:0] e_valB,
  input  logic [W-1:0] e_valC,
  input  logic [3:0]   e_dstE,
  input  logic [3:0]   e_dstM,
  input  logic         set_cc_en,
  input  logic         m_stall,
  input  logic         m_bubble,
  output logic [W-1:0] e_valE_fwd,
  output logic [3:0]   e_dstE_fwd,
  output logic         m_valid,
  output logic [3:0]   m_icode,
  output logic         m_cnd,
  output logic [W-1:0] m_valE,
  output logic [W-1:0] m_valA,
  output logic [3:0]   m_dstE,
  output logic [3:0]   m_dstM,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_fn_e;

  function automatic logic [W-1:0] add_64(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
    logic         c;
    logic [W-1:0] s;
    c = cin;
    s = '0;
    for (int unsigned i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction

  logic [W-1:0] alu_a, alu_b, sum, val_e;
  logic         is_op, op_ok, zf_d, sf_d, of_d, cnd, cc_we;
  logic [3:0]   dst_e_eff;
  alu_fn_e      fn;

  logic         cc_zf_q, cc_sf_q, cc_of_q;
  logic         m_valid_q, m_cnd_q;
  logic [3:0]   m_icode_q, m_dstE_q, m_dstM_q;
  logic [W-1:0] m_valE_q, m_valA_q;

  always_comb begin
    alu_a = '0;
    unique case (e_icode)
      4'h2, 4'h6:       alu_a = e_valA;
      4'h3, 4'h4, 4'h5: alu_a = e_valC;
      4'h8, 4'hA:       alu_a = -64'sd8;
      4'h9, 4'hB:       alu_a = 64'd8;
      default:          alu_a = '0;
    endcase
    alu_b = (e_icode == 4'h2 || e_icode == 4'h3) ? '0 : e_valB;
    is_op = (e_icode == 4'h6);
    op_ok = (e_ifun <= 4'd3);
    fn    = is_op ? alu_fn_e'(e_ifun[1:0]) : ALU_ADD;
  end

  // Subtract shares the single adder: aluB + ~aluA with carry-in 1.
  assign sum = add_64(alu_b, (fn == ALU_SUB) ? ~alu_a : alu_a, fn == ALU_SUB);

  always_comb begin
    val_e = '0;
    of_d  = 1'b0;
    if (e_icode <= 4'hB && !(is_op && !op_ok)) begin
      unique case (fn)
        ALU_ADD: begin
          val_e = sum;
          of_d  = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_b[W-1]);
        end
        ALU_SUB: begin
          val_e = sum;
          of_d  = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_b[W-1]);
        end
        ALU_AND: val_e = alu_b & alu_a;
        ALU_XOR: val_e = alu_b ^ alu_a;
        default: val_e = '0;
      endcase
    end
    zf_d = (val_e == '0);
    sf_d = val_e[W-1];
  end

  always_comb begin
    cnd = 1'b0;
    if (e_icode == 4'h2 || e_icode == 4'h7) begin
      unique case (e_ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (cc_sf_q ^ cc_of_q) | cc_zf_q;
        4'h2:    cnd = cc_sf_q ^ cc_of_q;
        4'h3:    cnd = cc_zf_q;
        4'h4:    cnd = !cc_zf_q;
        4'h5:    cnd = !(cc_sf_q ^ cc_of_q);
        4'h6:    cnd = !(cc_sf_q ^ cc_of_q) && !cc_zf_q;
        default: cnd = 1'b0;
      endcase
    end
    dst_e_eff = (e_icode == 4'h2 && !cnd) ? RNONE : e_dstE;
    cc_we     = e_valid && is_op && op_ok && set_cc_en && !m_stall && !m_bubble;
  end

  assign e_valE_fwd = val_e;
  assign e_dstE_fwd = e_valid ? dst_e_eff : RNONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf_q <= 1'b1;
      cc_sf_q <= 1'b0;
      cc_of_q <= 1'b0;
    end else if (cc_we) begin
      cc_zf_q <= zf_d;
      cc_sf_q <= sf_d;
      cc_of_q <= of_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || m_bubble || (!m_stall && !e_valid)) begin
      if (!rst_n) begin
        m_valid_q <= 1'b0;
        m_icode_q <= 4'h1;
        m_cnd_q   <= 1'b0;
        m_valE_q  <= '0;
        m_valA_q  <= '0;
        m_dstE_q  <= RNONE;
        m_dstM_q  <= RNONE;
      end else begin
        m_valid_q <= 1'b0;
        m_icode_q <= 4'h1;
        m_cnd_q   <= 1'b0;
        m_valE_q  <= '0;
        m_valA_q  <= '0;
        m_dstE_q  <= RNONE;
        m_dstM_q  <= RNONE;
      end
    end else if (!m_stall) begin
      m_valid_q <= 1'b1;
      m_icode_q <= e_icode;
      m_cnd_q   <= cnd;
      m_valE_q  <= val_e;
      m_valA_q  <= e_valA;
      m_dstE_q  <= dst_e_eff;
      m_dstM_q  <= e_dstM;
    end
  end

  assign m_valid = m_valid_q;
  assign m_icode = m_icode_q;
  assign m_cnd   = m_cnd_q;
  assign m_valE  = m_valE_q;
  assign m_valA  = m_valA_q;
  assign m_dstE  = m_dstE_q;
  assign m_dstM  = m_dstM_q;
  assign cc_zf   = cc_zf_q;
  assign cc_sf   = cc_sf_q;
  assign cc_of   = cc_of_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: expected E/M and CC values are queued when an
// instruction is driven and compared one cycle later.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        e_valid, set_cc_en, m_stall, m_bubble;
  logic [3:0]  e_icode, e_ifun, e_dstE, e_dstM;
  logic [63:0] e_valA, e_valB, e_valC;
  logic [63:0] e_valE_fwd, m_valE, m_valA;
  logic [3:0]  e_dstE_fwd, m_icode, m_dstE, m_dstM;
  logic        m_valid, m_cnd, cc_zf, cc_sf, cc_of;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic        v;
    logic [3:0]  ic;
    logic        c;
    logic [63:0] ve;
    logic [63:0] va;
    logic [3:0]  de;
    logic [3:0]  dm;
    logic        z, s, o;
  } exp_t;

  exp_t sb[$];

  execute_stage #(.W(64), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .set_cc_en(set_cc_en), .m_stall(m_stall), .m_bubble(m_bubble),
    .e_valE_fwd(e_valE_fwd), .e_dstE_fwd(e_dstE_fwd), .m_valid(m_valid), .m_icode(m_icode),
    .m_cnd(m_cnd), .m_valE(m_valE), .m_valA(m_valA), .m_dstE(m_dstE), .m_dstM(m_dstM),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    chk({tag, ".m_valid"}, 64'(m_valid), 64'(e.v));
    chk({tag, ".m_icode"}, 64'(m_icode), 64'(e.ic));
    chk({tag, ".m_cnd"},   64'(m_cnd),   64'(e.c));
    chk({tag, ".m_valE"},  m_valE,       e.ve);
    chk({tag, ".m_valA"},  m_valA,       e.va);
    chk({tag, ".m_dstE"},  64'(m_dstE),  64'(e.de));
    chk({tag, ".m_dstM"},  64'(m_dstM),  64'(e.dm));
    chk({tag, ".cc_zf"},   64'(cc_zf),   64'(e.z));
    chk({tag, ".cc_sf"},   64'(cc_sf),   64'(e.s));
    chk({tag, ".cc_of"},   64'(cc_of),   64'(e.o));
  endtask

  function automatic exp_t mk(input logic v, input logic [3:0] ic, input logic c,
                              input logic [63:0] ve, input logic [63:0] va,
                              input logic [3:0] de, input logic [3:0] dm,
                              input logic z, input logic s, input logic o);
    exp_t e;
    e.v = v; e.ic = ic; e.c = c; e.ve = ve; e.va = va;
    e.de = de; e.dm = dm; e.z = z; e.s = s; e.o = o;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic sc, input logic st, input logic bb);
    @(negedge clk);
    e_valid = v; e_icode = ic; e_ifun = fn;
    e_valA = a; e_valB = b; e_valC = c;
    e_dstE = de; e_dstM = dm;
    set_cc_en = sc; m_stall = st; m_bubble = bb;
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check_state(tag, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 4'h0, '0, '0, '0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    // irmovq to make m_* non-reset, then reset asynchronously mid-cycle
    drive(1'b1, 4'h3, 4'h0, 64'h0, 64'h0, 64'h55, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'h3, 1'b0, 64'h55, 64'h0, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0));
    tick_check("irmov");
    #2 rst_n = 1'b0;
    #1 check_state("async_reset", mk(1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'h6, 1'b0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                    4'h3, 4'hF, 1'b0, 1'b1, 1'b1));
    tick_check("add_ovf");

    drive(1'b1, 4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'h6, 1'b0, 64'h0, 64'h5, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0));
    tick_check("sub_zero");

    drive(1'b1, 4'h2, 4'h3, 64'hAA, 64'h0, 64'h0, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'h2, 1'b1, 64'hAA, 64'hAA, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0));
    tick_check("cmove");

    drive(1'b1, 4'h2, 4'h4, 64'hAA, 64'h0, 64'h0, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'h2, 1'b0, 64'hAA, 64'hAA, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0));
    tick_check("cmovne");

    drive(1'b1, 4'hA, 4'h0, 64'h77, 64'h100, 64'h0, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'hA, 1'b0, 64'hF8, 64'h77, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0));
    tick_check("push");

    drive(1'b1, 4'h9, 4'h0, 64'hF8, 64'hF8, 64'h0, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'h9, 1'b0, 64'h100, 64'hF8, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0));
    tick_check("ret");

    drive(1'b1, 4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h7, 4'hF, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'h6, 1'b0, 64'h2, 64'h1, 4'h7, 4'hF, 1'b1, 1'b0, 1'b0));
    tick_check("setcc_off");

    drive(1'b1, 4'h6, 4'h0, 64'h3, 64'h4, 64'h0, 4'h8, 4'hF, 1'b1, 1'b1, 1'b0);
    sb.push_back(mk(1'b1, 4'h6, 1'b0, 64'h2, 64'h1, 4'h7, 4'hF, 1'b1, 1'b0, 1'b0));
    tick_check("stall");

    drive(1'b1, 4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 4'h8, 4'hF, 1'b1, 1'b1, 1'b1);
    sb.push_back(mk(1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0));
    tick_check("stall_bubble");

    drive(1'b1, 4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 4'h8, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'h6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'h8, 4'hF,
                    1'b0, 1'b1, 1'b0));
    tick_check("sub_neg");

    drive(1'b1, 4'h7, 4'h1, 64'h0, 64'h10, 64'h40, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'h7, 1'b1, 64'h10, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0));
    tick_check("jle");

    drive(1'b1, 4'hC, 4'h0, 64'h0, 64'h9, 64'h0, 4'h5, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'hC, 1'b0, 64'h0, 64'h0, 4'h5, 4'hF, 1'b0, 1'b1, 1'b0));
    tick_check("bad_icode");

    drive(1'b1, 4'h6, 4'h5, 64'h1, 64'h2, 64'h0, 4'h6, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 4'h6, 1'b0, 64'h0, 64'h1, 4'h6, 4'hF, 1'b0, 1'b1, 1'b0));
    tick_check("bad_ifun");

    drive(1'b0, 4'h6, 4'h0, 64'h1, 64'h2, 64'h0, 4'h6, 4'hF, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0));
    tick_check("invalid");

    drive(1'b1, 4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0);
    #1;
    chk("fwd_valE", e_valE_fwd, 64'h1234);
    chk("fwd_dstE", 64'(e_dstE_fwd), 64'h2);
    sb.push_back(mk(1'b1, 4'h3, 1'b0, 64'h1234, 64'h0, 4'h2, 4'hF, 1'b0, 1'b1, 1'b0));
    tick_check("fwd_irmov");

    drive(1'b0, 4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0);
    #1;
    chk("fwd_dstE_invalid", 64'(e_dstE_fwd), 64'hF);
    sb.push_back(mk(1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0));
    tick_check("fwd_bubble");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline execute (E) stage plus the E/M pipeline register.
- Selects ALU operands from decode-stage values, computes valE, and evaluates the branch/cmov condition from the condition-code register.
- Holds the CC register (ZF/SF/OF) and latches results into the M-stage register under stall/bubble control.
- Sits directly downstream of the decode register. Consumes the 64-bit ripple adder (add_64) for add/sub.

Parameters:
- W, 64, datapath width (fixed at 64 for add_64 compatibility)
- RNONE, 4'hF, register ID meaning "no destination"

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- e_valid  in  1  E-stage holds a real instruction
- e_icode  in  4  instruction code
- e_ifun  in  4  function code
- e_valA  in  64  operand A from decode
- e_valB  in  64  operand B from decode
- e_valC  in  64  immediate/displacement
- e_dstE  in  4  E destination register ID
- e_dstM  in  4  M destination register ID
- set_cc_en  in  1  hazard unit permits CC update (low when M/W stage has an exception)
- m_stall  in  1  hold E/M register
- m_bubble  in  1  inject NOP into E/M register
- e_valE_fwd  out  64  combinational valE (forwarding path)
- e_dstE_fwd  out  4  combinational effective dstE (forwarding path)
- m_valid  out  1  registered valid
- m_icode  out  4  registered icode
- m_cnd  out  1  registered condition result
- m_valE  out  64  registered ALU result
- m_valA  out  64  registered valA (store data / return path)
- m_dstE  out  4  registered effective dstE
- m_dstM  out  4  registered dstM
- cc_zf, cc_sf, cc_of  out  1 each  current CC register

Behaviour:
- Reset is asynchronous, active-low. rst_n low immediately sets:
  - CC to ZF=1, SF=0, OF=0.
  - E/M register to the bubble state: m_valid=0, m_icode=4'h1, m_cnd=0, m_valE=0, m_valA=0, m_dstE=m_dstM=RNONE.
- aluA selection:
  - icode 2 (rrmov/cmov) or 6 (OPq): valA
  - icode 3, 4, 5: valC
  - icode 8 (call) or A (push): -8
  - icode 9 (ret) or B (pop): +8
  - all other icodes: 0
- aluB selection: 0 for icode 2 or 3; valB otherwise.
- ALU function:
  - icode 6: ifun 0 add, 1 sub, 2 and, 3 xor.
  - icode 6 with ifun > 3: valE=0 and no CC update.
  - All other icodes: add.
  - add: aluB+aluA via add_64.
  - sub: aluB-aluA, computed as aluB + (~aluA) + 1. Use add_64 twice (negate, then add) or an equivalent implementation.
  - Wrap-around is modulo 2^64.
- Flags:
  - ZF = (valE==0); SF = valE[63].
  - OF for add = (aluA[63]==aluB[63]) && (valE[63]!=aluB[63]).
  - OF for sub = (aluA[63]!=aluB[63]) && (valE[63]!=aluB[63]).
  - OF=0 for and/xor.
  - The add_64 overflow port is not used for OF (it is carry-based).
- CC write, at the rising edge: only when e_valid && icode==6 && ifun<=3 && set_cc_en && !m_stall && !m_bubble. Otherwise CC holds.
- Condition (icode 2 and 7 only; evaluated from the current registered CC, not this cycle's flags):
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): !ZF
  - ifun 5 (ge): !(SF^OF)
  - ifun 6 (g): !(SF^OF)&!ZF
  - ifun > 6: 0
  - For all other icodes, cnd = 0.
- Effective dstE: RNONE if icode==2 && !cnd; e_dstE otherwise.
- e_valE_fwd and e_dstE_fwd are purely combinational from the current inputs. e_dstE_fwd = RNONE when !e_valid.
- E/M register update at the rising edge, in priority order:
  1. m_bubble: load the bubble state. Bubble wins over stall.
  2. m_stall: hold all m_* outputs.
  3. Otherwise: load the computed values. If e_valid=0, load the bubble state.
- Invalid icode (> 4'hB) with e_valid=1: valE=0, cnd=0, dstE passes through unchanged, no CC write, m_valid=1 (status handled downstream).
- Latency: one cycle from E inputs to m_* outputs; forwarding outputs have zero latency.

Test Plan:
1. Reset: rst_n low mid-cycle -> outputs change immediately to m_valid=0, m_icode=1, m_dstE=m_dstM=F, ZF=1, SF=0, OF=0, with no clock edge needed.
2. OPq add overflow: icode 6, ifun 0, valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> next cycle m_valE=0x8000_0000_0000_0000, SF=1, OF=1, ZF=0.
3. OPq sub to zero, then a cmov:
   - icode 6, ifun 1, valA=valB=5 -> m_valE=0, ZF=1.
   - Following cmove (icode 2, ifun 3, dstE=3) -> m_cnd=1, m_dstE=3.
   - Following cmovne (ifun 4) -> m_cnd=0, m_dstE=F.
4. push / ret: icode A, valB=0x100 -> m_valE=0xF8. icode 9, valB=0xF8 -> m_valE=0x100. CC unchanged in both cases.
5. CC gating: OPq with set_cc_en=0 -> CC unchanged. OPq with m_stall=1 -> m_* and CC hold. OPq with m_stall=1 and m_bubble=1 -> bubble state loaded, CC unchanged.
6. Forwarding: irmovq (icode 3, valC=0x1234, dstE=2) -> same cycle e_valE_fwd=0x1234, e_dstE_fwd=2. With e_valid=0 -> e_dstE_fwd=F.
